ps2_key_poller: RTL and testbench

- Bus master that sequences reads of the PS/2 key-state controller's ten key registers (E W A S D, KP7 KP8 KP4 KP5 KP6).
- Runs periodic scans and assembles a 10-bit key bitmap.
- Flags which keys changed since the previous scan and raises a one-cycle event pulse for game logic.
- Sits between the PS/2 controller's bus port and the game/CPU side, so game logic never issues per-key bus transactions itself.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_poll_timer.sv | 36 +++
 rtl/ps2_key_poller.sv | 116 +++++++++++
 tb/tb_ps2_key_poller.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key poller: key register addresses,
// key count and poll FSM state type.
package ps2_pkg;

  localparam int unsigned NUM_KEYS = 10;

  localparam logic [3:0] KEY_E   = 4'd0;
  localparam logic [3:0] KEY_W   = 4'd1;
  localparam logic [3:0] KEY_A   = 4'd2;
  localparam logic [3:0] KEY_S   = 4'd3;
  localparam logic [3:0] KEY_D   = 4'd4;
  localparam logic [3:0] KEY_KP7 = 4'd5;
  localparam logic [3:0] KEY_KP8 = 4'd6;
  localparam logic [3:0] KEY_KP4 = 4'd7;
  localparam logic [3:0] KEY_KP5 = 4'd8;
  localparam logic [3:0] KEY_KP6 = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN_REQ,
    ST_SCAN_WAIT,
    ST_SCAN_SAMPLE,
    ST_SCAN_FINISH,
    ST_COMMIT
  } poll_state_e;

endpackage

// File: rtl/ps2_poll_timer.sv
// Idle-interval counter: counts enabled cycles and flags expiry on the
// cycle the count reaches POLL_INTERVAL-1; clear has priority.
module ps2_poll_timer #(
  parameter int unsigned POLL_INTERVAL = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int unsigned CW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = count_en_i && (cnt_q == CW'(POLL_INTERVAL - 1));

endmodule

// File: rtl/ps2_key_poller.sv
// Bus master that scans the PS/2 key-state registers, assembles a key
// bitmap and reports per-key changes with a one-cycle event pulse.
module ps2_key_poller #(
  parameter int unsigned BUS_WIDTH     = 32,
  parameter int unsigned CTRL_WIDTH    = 8,
  parameter int unsigned NUM_KEYS      = ps2_pkg::NUM_KEYS,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned POLL_INTERVAL = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  scan_now,
  output logic                  bus_ack,
  output logic [BUS_WIDTH-1:0]  bus_addr,
  input  logic [BUS_WIDTH-1:0]  bus_rdata,
  input  logic [CTRL_WIDTH-1:0] bus_ctrl,
  output logic [NUM_KEYS-1:0]   key_map,
  output logic [NUM_KEYS-1:0]   key_changed,
  output logic                  key_event,
  output logic                  scan_busy
);

  import ps2_pkg::*;

  poll_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [NUM_KEYS-1:0]   shadow_q, shadow_d;
  logic [NUM_KEYS-1:0]   map_q, map_d;
  logic [NUM_KEYS-1:0]   changed_q, changed_d;
  logic                  event_q, event_d;
  logic                  in_idle;
  logic                  start_scan;
  logic                  timer_expire;
  logic                  unused_bus_bits;

  assign in_idle    = (state_q == ST_IDLE);
  // scan_now and interval expiry collapse into a single start; busy ignores both.
  assign start_scan = in_idle && (scan_now || timer_expire);

  ps2_poll_timer #(
    .POLL_INTERVAL(POLL_INTERVAL)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_en_i (in_idle && enable),
    .clear_i    (start_scan || !in_idle),
    .expire_o   (timer_expire)
  );

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    shadow_d  = shadow_q;
    map_d     = map_q;
    changed_d = changed_q;
    event_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_scan) state_d = ST_SCAN_REQ;
      end
      ST_SCAN_REQ:  state_d = ST_SCAN_WAIT;
      ST_SCAN_WAIT: state_d = ST_SCAN_SAMPLE;
      ST_SCAN_SAMPLE: begin
        if (!bus_ctrl[0]) begin
          shadow_d[index_q] = bus_rdata[0];
          state_d           = ST_SCAN_FINISH;
        end
      end
      ST_SCAN_FINISH: begin
        if (index_q == ADDR_WIDTH'(NUM_KEYS - 1)) begin
          state_d = ST_COMMIT;
        end else begin
          index_d = index_q + ADDR_WIDTH'(1);
          state_d = ST_SCAN_REQ;
        end
      end
      ST_COMMIT: begin
        index_d   = '0;
        changed_d = shadow_q ^ map_q;
        map_d     = shadow_q;
        event_d   = |(shadow_q ^ map_q);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      shadow_q  <= '0;
      map_q     <= '0;
      changed_q <= '0;
      event_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      shadow_q  <= shadow_d;
      map_q     <= map_d;
      changed_q <= changed_d;
      event_q   <= event_d;
    end
  end

  assign bus_ack     = (state_q == ST_SCAN_REQ);
  assign bus_addr    = BUS_WIDTH'(index_q);
  assign scan_busy   = !in_idle;
  assign key_map     = map_q;
  assign key_changed = changed_q;
  assign key_event   = event_q;

  assign unused_bus_bits = ^{bus_rdata[BUS_WIDTH-1:1], bus_ctrl[CTRL_WIDTH-1:1]};

endmodule

// File: tb/tb_ps2_key_poller.sv
// Self-checking bench for ps2_key_poller: slave model, scan-timing model
// and directed scenarios with literal expectations.
module tb_ps2_key_poller;

  localparam int unsigned BW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned NK = 10;
  localparam int unsigned AW = 4;
  localparam int unsigned P  = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          scan_now;
  logic          bus_ack;
  logic [BW-1:0] bus_addr;
  logic [BW-1:0] bus_rdata;
  logic [CW-1:0] bus_ctrl;
  logic [NK-1:0] key_map;
  logic [NK-1:0] key_changed;
  logic          key_event;
  logic          scan_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_key_poller #(
    .BUS_WIDTH    (BW),
    .CTRL_WIDTH   (CW),
    .NUM_KEYS     (NK),
    .ADDR_WIDTH   (AW),
    .POLL_INTERVAL(P)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .scan_now   (scan_now),
    .bus_ack    (bus_ack),
    .bus_addr   (bus_addr),
    .bus_rdata  (bus_rdata),
    .bus_ctrl   (bus_ctrl),
    .key_map    (key_map),
    .key_changed(key_changed),
    .key_event  (key_event),
    .scan_busy  (scan_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: latches the address on ack; optional wait on addr 3 with
  // inverted data while waiting, so an early capture reads the wrong bit.
  logic [NK-1:0] keys;
  logic          wait_en;
  logic [AW-1:0] lat_addr;
  int            age;
  logic          slave_wait;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_addr <= '0;
      age      <= 100;
    end else if (bus_ack) begin
      lat_addr <= bus_addr[AW-1:0];
      age      <= 1;
    end else if (age < 100) begin
      age <= age + 1;
    end
  end

  assign slave_wait = wait_en && (lat_addr == 4'd3) && (age >= 2) && (age <= 6);
  assign bus_ctrl   = {7'b1010010, slave_wait};
  assign bus_rdata  = {31'h2AAA_AAAA, keys[lat_addr] ^ slave_wait};

  // Timing model: a scan is a run of busy cycles with transactions every
  // 4 cycles, stretched by the slave wait after key 3.
  bit            m_busy;
  int            m_t, m_len, m_extra, m_cnt;
  logic [NK-1:0] m_map, m_changed;
  bit            m_event;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_t = 0; m_len = 0; m_extra = 0; m_cnt = 0;
      m_map = '0; m_changed = '0; m_event = 0;
    end else begin
      m_event = 0;
      if (!m_busy) begin
        if (scan_now || (enable && m_cnt == P - 1)) begin
          m_busy  = 1;
          m_t     = 0;
          m_extra = wait_en ? 5 : 0;
          m_len   = 4 * NK + 1 + m_extra;
          m_cnt   = 0;
        end else if (enable) begin
          m_cnt++;
        end
      end else if (m_t == m_len - 1) begin
        m_changed = keys ^ m_map;
        m_event   = (m_changed != '0);
        m_map     = keys;
        m_busy    = 0;
      end else begin
        m_t++;
      end
    end
  end

  function automatic int exp_addr(input int t, input int extra);
    for (int k = 0; k < NK; k++)
      if (t == 4 * k + ((k > 3) ? extra : 0)) return k;
    return -1;
  endfunction

  always @(negedge clk) begin
    int ea;
    ea = m_busy ? exp_addr(m_t, m_extra) : -1;
    check("bus_ack", 32'(bus_ack), 32'(ea >= 0));
    if (ea >= 0) check("bus_addr", bus_addr, 32'(ea));
    check("addr_range", 32'(bus_addr < NK), 32'd1);
    check("scan_busy", 32'(scan_busy), 32'(m_busy));
    check("key_map", 32'(key_map), 32'(m_map));
    check("key_changed", 32'(key_changed), 32'(m_changed));
    check("key_event", 32'(key_event), 32'(m_event));
  end

  int   busy_run = 0, idle_run = 0, last_len = 0, last_gap = 0;
  int   ev_count = 0, ack_count = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      busy_run  = 0;
      idle_run  = 0;
      prev_busy = 1'b0;
    end else begin
      if (scan_busy) begin
        if (!prev_busy) begin last_gap = idle_run; idle_run = 0; end
        busy_run++;
      end else begin
        if (prev_busy) begin last_len = busy_run; busy_run = 0; end
        idle_run++;
      end
      prev_busy = scan_busy;
      if (key_event) ev_count++;
      if (bus_ack) ack_count++;
    end
  end

  task automatic wait_done(input string name);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      if (!scan_busy) done = 1;
    end
    if (!done) begin
      errors++;
      $display("FAIL %s: scan_busy still 1 after 300 cycles, expected 0", name);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_start(input string name);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (scan_busy) seen = 1;
    end
    if (!seen) begin
      errors++;
      $display("FAIL %s: scan_busy still 0 after 200 cycles, expected 1", name);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_scan();
    @(negedge clk) scan_now = 1'b1;
    @(negedge clk) scan_now = 1'b0;
  endtask

  task automatic manual_scan(input string name, input int exp_len,
                             input logic [NK-1:0] exp_map, input logic [NK-1:0] exp_chg,
                             input int exp_ev);
    int ev0, ack0;
    ev0  = ev_count;
    ack0 = ack_count;
    pulse_scan();
    wait_done(name);
    check({name, "_len"}, 32'(last_len), 32'(exp_len));
    check({name, "_map"}, 32'(key_map), 32'(exp_map));
    check({name, "_chg"}, 32'(key_changed), 32'(exp_chg));
    check({name, "_events"}, 32'(ev_count - ev0), 32'(exp_ev));
    check({name, "_acks"}, 32'(ack_count - ack0), 32'(NK));
  endtask

  initial begin
    bit hit;
    int acks0;
    reset = 1'b1; enable = 1'b0; scan_now = 1'b0; keys = '0; wait_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_map", 32'(key_map), 32'd0);
    check("rst_ack", 32'(bus_ack), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_busy", 32'(scan_busy), 32'd0);
    reset = 1'b0;

    repeat (2000) @(negedge clk);
    check("quiet_acks", 32'(ack_count), 32'd0);
    check("quiet_events", 32'(ev_count), 32'd0);
    check("quiet_map", 32'(key_map), 32'd0);

    keys = 10'b01_0000_0100;
    manual_scan("scan1", 41, 10'b01_0000_0100, 10'b01_0000_0100, 1);
    manual_scan("scan2", 41, 10'b01_0000_0100, 10'b00_0000_0000, 0);
    keys = 10'b01_0000_0000;
    manual_scan("scan3", 41, 10'b01_0000_0000, 10'b00_0000_0100, 1);

    // Periodic mode, with a scan_now arriving mid-scan.
    enable = 1'b1;
    wait_start("per_start1");
    repeat (8) @(negedge clk);
    pulse_scan();
    wait_done("per_done1");
    check("per_len1", 32'(last_len), 32'd41);
    wait_start("per_start2");
    check("per_gap", 32'(last_gap), 32'd20);
    wait_done("per_done2");

    // scan_now coinciding with interval expiry starts exactly one scan.
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (m_cnt == P - 1 && !m_busy) hit = 1;
    end
    check("coincide_found", 32'(hit), 32'd1);
    scan_now = 1'b1;
    @(negedge clk) scan_now = 1'b0;
    wait_done("coincide_done");
    check("coincide_len", 32'(last_len), 32'd41);
    check("coincide_gap", 32'(last_gap), 32'd20);

    // Dropping enable mid-scan lets the scan finish, then stays idle.
    wait_start("drop_start");
    enable = 1'b0;
    wait_done("drop_done");
    check("drop_len", 32'(last_len), 32'd41);
    acks0 = ack_count;
    repeat (100) @(negedge clk);
    check("drop_idle_acks", 32'(ack_count - acks0), 32'd0);

    // Slave wait on key 3; data read during wait is inverted.
    keys = 10'b01_0000_1000;
    wait_en = 1'b1;
    manual_scan("wait", 46, 10'b01_0000_1000, 10'b00_0000_1000, 1);
    wait_en = 1'b0;

    // Reset during the addr 6 transaction.
    pulse_scan();
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (bus_ack && bus_addr == 32'd6) hit = 1;
    end
    check("rst6_found", 32'(hit), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst6_ack", 32'(bus_ack), 32'd0);
    check("rst6_addr", bus_addr, 32'd0);
    check("rst6_busy", 32'(scan_busy), 32'd0);
    check("rst6_map", 32'(key_map), 32'd0);
    check("rst6_chg", 32'(key_changed), 32'd0);
    check("rst6_event", 32'(key_event), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    manual_scan("post_rst", 41, 10'b01_0000_1000, 10'b01_0000_1000, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
